// File: rtl/rs_scheduler.sv
// Reservation-station scheduler: issues ALU ops into free entries, wakes operands from the CDB,
// and dispatches the lowest-index ready entry to the ALU. Optional macro: RS_ISSUE_BYPASS_EN.
module rs_scheduler #(
    parameter int unsigned RS_SIZE  = 16,
    parameter int unsigned RS_BIT   = 4,
    parameter int unsigned ROB_BIT  = 4,
    parameter int unsigned OP_WIDTH = 6
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    input  logic                clear_in,
    input  logic                issue_valid,
    input  logic [OP_WIDTH-1:0] issue_op,
    input  logic [ROB_BIT-1:0]  issue_rob,
    input  logic [31:0]         issue_vj,
    input  logic [31:0]         issue_vk,
    input  logic                issue_qj_v,
    input  logic                issue_qk_v,
    input  logic [ROB_BIT-1:0]  issue_qj,
    input  logic [ROB_BIT-1:0]  issue_qk,
    input  logic [31:0]         issue_imm,
    input  logic [31:0]         issue_pc,
    output logic                full,
    input  logic                cdb_valid,
    input  logic [ROB_BIT-1:0]  cdb_rob,
    input  logic [31:0]         cdb_val,
    output logic                alu_valid,
    input  logic                alu_ready,
    output logic [OP_WIDTH-1:0] alu_op,
    output logic [ROB_BIT-1:0]  alu_rob,
    output logic [31:0]         alu_vj,
    output logic [31:0]         alu_vk,
    output logic [31:0]         alu_imm,
    output logic [31:0]         alu_pc
);

    logic [RS_SIZE-1:0]  busy_q, busy_d;
    logic [RS_SIZE-1:0]  qj_v_q, qj_v_d;
    logic [RS_SIZE-1:0]  qk_v_q, qk_v_d;
    logic [OP_WIDTH-1:0] op_q  [RS_SIZE];
    logic [OP_WIDTH-1:0] op_d  [RS_SIZE];
    logic [ROB_BIT-1:0]  rob_q [RS_SIZE];
    logic [ROB_BIT-1:0]  rob_d [RS_SIZE];
    logic [ROB_BIT-1:0]  qj_q  [RS_SIZE];
    logic [ROB_BIT-1:0]  qj_d  [RS_SIZE];
    logic [ROB_BIT-1:0]  qk_q  [RS_SIZE];
    logic [ROB_BIT-1:0]  qk_d  [RS_SIZE];
    logic [31:0]         vj_q  [RS_SIZE];
    logic [31:0]         vj_d  [RS_SIZE];
    logic [31:0]         vk_q  [RS_SIZE];
    logic [31:0]         vk_d  [RS_SIZE];
    logic [31:0]         imm_q [RS_SIZE];
    logic [31:0]         imm_d [RS_SIZE];
    logic [31:0]         pc_q  [RS_SIZE];
    logic [31:0]         pc_d  [RS_SIZE];

    logic                alu_valid_q, alu_valid_d;
    logic [OP_WIDTH-1:0] alu_op_q, alu_op_d;
    logic [ROB_BIT-1:0]  alu_rob_q, alu_rob_d;
    logic [31:0]         alu_vj_q, alu_vj_d;
    logic [31:0]         alu_vk_q, alu_vk_d;
    logic [31:0]         alu_imm_q, alu_imm_d;
    logic [31:0]         alu_pc_q, alu_pc_d;

    logic [RS_SIZE-1:0]  ready_c;
    logic [RS_BIT-1:0]   free_idx_c, ready_idx_c;
    logic                has_free_c, has_ready_c;
    logic [31:0]         issue_vj_c, issue_vk_c;
    logic                issue_qj_v_c, issue_qk_v_c;

    // Lowest-index free and ready entry selection from registered state.
    always_comb begin
        ready_c     = busy_q & ~qj_v_q & ~qk_v_q;
        has_free_c  = ~(&busy_q);
        has_ready_c = |ready_c;
        free_idx_c  = '0;
        ready_idx_c = '0;
        for (int i = int'(RS_SIZE) - 1; i >= 0; i--) begin
            if (!busy_q[i]) free_idx_c = RS_BIT'(i);
            if (ready_c[i]) ready_idx_c = RS_BIT'(i);
        end
    end

    assign full = ~has_free_c;

    // Operand values written at issue; the bypass resolves a same-cycle broadcast.
    always_comb begin
        issue_vj_c   = issue_vj;
        issue_vk_c   = issue_vk;
        issue_qj_v_c = issue_qj_v;
        issue_qk_v_c = issue_qk_v;
`ifdef RS_ISSUE_BYPASS_EN
        if (issue_qj_v && cdb_valid && (issue_qj == cdb_rob)) begin
            issue_vj_c   = cdb_val;
            issue_qj_v_c = 1'b0;
        end
        if (issue_qk_v && cdb_valid && (issue_qk == cdb_rob)) begin
            issue_vk_c   = cdb_val;
            issue_qk_v_c = 1'b0;
        end
`endif
    end

    always_comb begin
        busy_d      = busy_q;
        qj_v_d      = qj_v_q;
        qk_v_d      = qk_v_q;
        op_d        = op_q;
        rob_d       = rob_q;
        qj_d        = qj_q;
        qk_d        = qk_q;
        vj_d        = vj_q;
        vk_d        = vk_q;
        imm_d       = imm_q;
        pc_d        = pc_q;
        alu_valid_d = alu_valid_q;
        alu_op_d    = alu_op_q;
        alu_rob_d   = alu_rob_q;
        alu_vj_d    = alu_vj_q;
        alu_vk_d    = alu_vk_q;
        alu_imm_d   = alu_imm_q;
        alu_pc_d    = alu_pc_q;

        if (!rdy_in) begin
            busy_d = busy_q;
        end else if (clear_in) begin
            busy_d      = '0;
            alu_valid_d = 1'b0;
        end else begin
            for (int i = 0; i < int'(RS_SIZE); i++) begin
                if (busy_q[i] && qj_v_q[i] && cdb_valid && (qj_q[i] == cdb_rob)) begin
                    vj_d[i]   = cdb_val;
                    qj_v_d[i] = 1'b0;
                end
                if (busy_q[i] && qk_v_q[i] && cdb_valid && (qk_q[i] == cdb_rob)) begin
                    vk_d[i]   = cdb_val;
                    qk_v_d[i] = 1'b0;
                end
            end

            if (!alu_valid_q || alu_ready) begin
                if (has_ready_c) begin
                    alu_valid_d         = 1'b1;
                    alu_op_d            = op_q[ready_idx_c];
                    alu_rob_d           = rob_q[ready_idx_c];
                    alu_vj_d            = vj_q[ready_idx_c];
                    alu_vk_d            = vk_q[ready_idx_c];
                    alu_imm_d           = imm_q[ready_idx_c];
                    alu_pc_d            = pc_q[ready_idx_c];
                    busy_d[ready_idx_c] = 1'b0;
                end else begin
                    alu_valid_d = 1'b0;
                end
            end

            // The target is never busy, so it cannot collide with wakeup or dispatch.
            if (issue_valid && has_free_c) begin
                busy_d[free_idx_c] = 1'b1;
                op_d[free_idx_c]   = issue_op;
                rob_d[free_idx_c]  = issue_rob;
                vj_d[free_idx_c]   = issue_vj_c;
                vk_d[free_idx_c]   = issue_vk_c;
                qj_v_d[free_idx_c] = issue_qj_v_c;
                qk_v_d[free_idx_c] = issue_qk_v_c;
                qj_d[free_idx_c]   = issue_qj;
                qk_d[free_idx_c]   = issue_qk;
                imm_d[free_idx_c]  = issue_imm;
                pc_d[free_idx_c]   = issue_pc;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy_q      <= '0;
            qj_v_q      <= '0;
            qk_v_q      <= '0;
            for (int i = 0; i < int'(RS_SIZE); i++) begin
                op_q[i]  <= '0;
                rob_q[i] <= '0;
                qj_q[i]  <= '0;
                qk_q[i]  <= '0;
                vj_q[i]  <= '0;
                vk_q[i]  <= '0;
                imm_q[i] <= '0;
                pc_q[i]  <= '0;
            end
            alu_valid_q <= 1'b0;
            alu_op_q    <= '0;
            alu_rob_q   <= '0;
            alu_vj_q    <= '0;
            alu_vk_q    <= '0;
            alu_imm_q   <= '0;
            alu_pc_q    <= '0;
        end else begin
            busy_q      <= busy_d;
            qj_v_q      <= qj_v_d;
            qk_v_q      <= qk_v_d;
            op_q        <= op_d;
            rob_q       <= rob_d;
            qj_q        <= qj_d;
            qk_q        <= qk_d;
            vj_q        <= vj_d;
            vk_q        <= vk_d;
            imm_q       <= imm_d;
            pc_q        <= pc_d;
            alu_valid_q <= alu_valid_d;
            alu_op_q    <= alu_op_d;
            alu_rob_q   <= alu_rob_d;
            alu_vj_q    <= alu_vj_d;
            alu_vk_q    <= alu_vk_d;
            alu_imm_q   <= alu_imm_d;
            alu_pc_q    <= alu_pc_d;
        end
    end

    assign alu_valid = alu_valid_q;
    assign alu_op    = alu_op_q;
    assign alu_rob   = alu_rob_q;
    assign alu_vj    = alu_vj_q;
    assign alu_vk    = alu_vk_q;
    assign alu_imm   = alu_imm_q;
    assign alu_pc    = alu_pc_q;

endmodule

// File: tb/tb_rs_scheduler.sv
// Directed self-checking bench for rs_scheduler; expected values are hand-computed per step.
module tb_rs_scheduler;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, clear_in;
    logic        issue_valid;
    logic [5:0]  issue_op;
    logic [3:0]  issue_rob, issue_qj, issue_qk;
    logic [31:0] issue_vj, issue_vk, issue_imm, issue_pc;
    logic        issue_qj_v, issue_qk_v;
    logic        full;
    logic        cdb_valid;
    logic [3:0]  cdb_rob;
    logic [31:0] cdb_val;
    logic        alu_valid, alu_ready;
    logic [5:0]  alu_op;
    logic [3:0]  alu_rob;
    logic [31:0] alu_vj, alu_vk, alu_imm, alu_pc;

    int n_checks = 0;
    int n_fail   = 0;

    rs_scheduler dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
        .issue_valid(issue_valid), .issue_op(issue_op), .issue_rob(issue_rob),
        .issue_vj(issue_vj), .issue_vk(issue_vk), .issue_qj_v(issue_qj_v),
        .issue_qk_v(issue_qk_v), .issue_qj(issue_qj), .issue_qk(issue_qk),
        .issue_imm(issue_imm), .issue_pc(issue_pc), .full(full),
        .cdb_valid(cdb_valid), .cdb_rob(cdb_rob), .cdb_val(cdb_val),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_op(alu_op),
        .alu_rob(alu_rob), .alu_vj(alu_vj), .alu_vk(alu_vk),
        .alu_imm(alu_imm), .alu_pc(alu_pc)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [5:0] op, input logic [3:0] rob,
                         input logic [31:0] vj, input logic [31:0] vk,
                         input logic qjv, input logic [3:0] qj,
                         input logic [31:0] pc);
        issue_valid = 1'b1;
        issue_op    = op;
        issue_rob   = rob;
        issue_vj    = vj;
        issue_vk    = vk;
        issue_qj_v  = qjv;
        issue_qj    = qj;
        issue_qk_v  = 1'b0;
        issue_qk    = 4'h0;
        issue_pc    = pc;
        issue_imm   = pc ^ 32'h0000_FFFF;
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; clear_in = 1'b0;
        issue_valid = 1'b0; issue_op = '0; issue_rob = '0; issue_qj = '0; issue_qk = '0;
        issue_vj = '0; issue_vk = '0; issue_imm = '0; issue_pc = '0;
        issue_qj_v = 1'b0; issue_qk_v = 1'b0;
        cdb_valid = 1'b0; cdb_rob = '0; cdb_val = '0; alu_ready = 1'b1;

        // Reset state
        tick(); tick();
        rst_in = 1'b0;
        chk("rst_alu_valid", 32'(alu_valid), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_alu_rob", 32'(alu_rob), 32'd0);
        chk("rst_alu_vj", alu_vj, 32'd0);

        // Resolved issue: two-edge latency
        issue(6'd3, 4'd2, 32'd5, 32'd7, 1'b0, 4'd0, 32'h100);
        tick();
        issue_valid = 1'b0;
        chk("lat_not_yet", 32'(alu_valid), 32'd0);
        tick();
        chk("lat_valid", 32'(alu_valid), 32'd1);
        chk("lat_op", 32'(alu_op), 32'd3);
        chk("lat_rob", 32'(alu_rob), 32'd2);
        chk("lat_vj", alu_vj, 32'd5);
        chk("lat_vk", alu_vk, 32'd7);
        chk("lat_imm", alu_imm, 32'h0000_FEFF);
        chk("lat_pc", alu_pc, 32'h100);
        tick();
        chk("lat_drop", 32'(alu_valid), 32'd0);

        // Wakeup through CDB
        issue(6'd4, 4'd1, 32'd0, 32'd8, 1'b1, 4'd4, 32'h200);
        tick();
        issue_valid = 1'b0;
        tick();
        chk("wake_wait", 32'(alu_valid), 32'd0);
        cdb_valid = 1'b1; cdb_rob = 4'd4; cdb_val = 32'h55;
        tick();
        cdb_valid = 1'b0;
        chk("wake_edge", 32'(alu_valid), 32'd0);
        tick();
        chk("wake_valid", 32'(alu_valid), 32'd1);
        chk("wake_rob", 32'(alu_rob), 32'd1);
        chk("wake_vj", alu_vj, 32'h55);
        chk("wake_vk", alu_vk, 32'd8);
        tick();
        chk("wake_drop", 32'(alu_valid), 32'd0);

        // Fill all 16 entries waiting on tag 9
        for (int i = 0; i < 16; i++) begin
            issue(6'd1, 4'(i), 32'd0, 32'(i), 1'b1, 4'd9, 32'h1000 + 32'(i));
            tick();
            if (i == 14) chk("fill_not_full", 32'(full), 32'd0);
        end
        chk("fill_full", 32'(full), 32'd1);
        issue(6'd2, 4'd0, 32'd0, 32'd0, 1'b1, 4'd9, 32'hBAD);
        tick();
        issue_valid = 1'b0;
        chk("fill_still_full", 32'(full), 32'd1);
        cdb_valid = 1'b1; cdb_rob = 4'd9; cdb_val = 32'h99;
        tick();
        cdb_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("order_valid", 32'(alu_valid), 32'd1);
            chk("order_pc", alu_pc, 32'h1000 + 32'(i));
            chk("order_vj", alu_vj, 32'h99);
            if (i == 0) chk("order_full_freed", 32'(full), 32'd0);
        end
        tick();
        chk("order_ignored_17th", 32'(alu_valid), 32'd0);

        // Backpressure holds outputs stable
        alu_ready = 1'b0;
        issue(6'd5, 4'd3, 32'h33, 32'd0, 1'b0, 4'd0, 32'h300);
        tick();
        issue(6'd6, 4'd5, 32'h55, 32'd1, 1'b0, 4'd0, 32'h500);
        tick();
        issue_valid = 1'b0;
        chk("hold_load", 32'(alu_rob), 32'd3);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("hold_valid", 32'(alu_valid), 32'd1);
            chk("hold_rob", 32'(alu_rob), 32'd3);
            chk("hold_vj", alu_vj, 32'h33);
        end
        alu_ready = 1'b1;
        tick();
        chk("hold_next_valid", 32'(alu_valid), 32'd1);
        chk("hold_next_rob", 32'(alu_rob), 32'd5);
        chk("hold_next_vj", alu_vj, 32'h55);
        tick();
        chk("hold_drop", 32'(alu_valid), 32'd0);

        // Flush with busy entries and a valid dispatch
        alu_ready = 1'b0;
        issue(6'd7, 4'd7, 32'h77, 32'd0, 1'b0, 4'd0, 32'h700);
        tick();
        for (int i = 0; i < 5; i++) begin
            issue(6'd8, 4'(8 + i), 32'd0, 32'd0, 1'b1, 4'd12, 32'h800);
            tick();
        end
        issue_valid = 1'b0;
        chk("pre_clr_valid", 32'(alu_valid), 32'd1);
        chk("pre_clr_rob", 32'(alu_rob), 32'd7);
        clear_in = 1'b1;
        tick();
        clear_in = 1'b0;
        chk("clr_full", 32'(full), 32'd0);
        chk("clr_valid", 32'(alu_valid), 32'd0);
        alu_ready = 1'b1;
        issue(6'd9, 4'hB, 32'hBB, 32'd0, 1'b0, 4'd0, 32'hB00);
        tick();
        issue_valid = 1'b0;
        tick();
        chk("post_clr_valid", 32'(alu_valid), 32'd1);
        chk("post_clr_rob", 32'(alu_rob), 32'hB);
        tick();
        chk("post_clr_drop", 32'(alu_valid), 32'd0);
        cdb_valid = 1'b1; cdb_rob = 4'd12; cdb_val = 32'hC;
        tick();
        cdb_valid = 1'b0;
        tick();
        chk("clr_flushed_0", 32'(alu_valid), 32'd0);
        tick();
        chk("clr_flushed_1", 32'(alu_valid), 32'd0);

        // Global hold
        rdy_in = 1'b0;
        issue(6'd10, 4'hC, 32'hCC, 32'd0, 1'b0, 4'd0, 32'hC00);
        tick(); tick();
        issue_valid = 1'b0;
        chk("rdy_hold_valid", 32'(alu_valid), 32'd0);
        rdy_in = 1'b1;
        tick();
        chk("rdy_hold_after", 32'(alu_valid), 32'd0);

        // Issue racing a broadcast of its own source tag
        issue(6'd11, 4'hD, 32'd0, 32'd0, 1'b1, 4'd6, 32'hD00);
        cdb_valid = 1'b1; cdb_rob = 4'd6; cdb_val = 32'hA;
        tick();
        issue_valid = 1'b0; cdb_valid = 1'b0;
        tick();
`ifdef RS_ISSUE_BYPASS_EN
        chk("bypass_valid", 32'(alu_valid), 32'd1);
        chk("bypass_vj", alu_vj, 32'hA);
        chk("bypass_rob", 32'(alu_rob), 32'hD);
`else
        chk("nobypass_wait", 32'(alu_valid), 32'd0);
        cdb_valid = 1'b1; cdb_rob = 4'd6; cdb_val = 32'h77;
        tick();
        cdb_valid = 1'b0;
        tick();
        chk("nobypass_valid", 32'(alu_valid), 32'd1);
        chk("nobypass_vj", alu_vj, 32'h77);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rs_scheduler.md
Name: rs_scheduler

Overview:
- Reservation-station scheduler for the out-of-order core.
- Accepts issued ALU instructions from the decoder into free RS entries and captures operands broadcast on the CDB.
- Selects one ready entry per cycle and sends it to the ALU through a valid/ready handshake.
- Sits between the decoder/ROB issue stage and the ALU. Free-slot and ready-slot selection use lowest-index priority.

Parameters:
- RS_SIZE, 16, number of RS entries (power of 2)
- RS_BIT, 4, log2(RS_SIZE)
- ROB_BIT, 4, ROB tag width
- OP_WIDTH, 6, decoded ALU opcode width

Ports:
- clk_in  input  1  clock
- rst_in  input  1  synchronous active-high reset
- rdy_in  input  1  global ready; when low, all state holds
- clear_in  input  1  mispredict flush
- issue_valid  input  1  decoder presents an instruction
- issue_op  input  OP_WIDTH  opcode
- issue_rob  input  ROB_BIT  destination ROB tag
- issue_vj, issue_vk  input  32  operand values
- issue_qj_v, issue_qk_v  input  1  operand pending (1 = wait on tag)
- issue_qj, issue_qk  input  ROB_BIT  producer tags
- issue_imm  input  32  immediate
- issue_pc  input  32  instruction PC
- full  output  1  no free entry (combinational from entry state)
- cdb_valid  input  1  CDB broadcast valid
- cdb_rob  input  ROB_BIT  broadcasting tag
- cdb_val  input  32  broadcast value
- alu_valid  output  1  dispatch valid (registered)
- alu_ready  input  1  ALU accepts
- alu_op  output  OP_WIDTH  dispatched opcode (registered)
- alu_rob  output  ROB_BIT  dispatched ROB tag (registered)
- alu_vj, alu_vk, alu_imm, alu_pc  output  32 each  dispatched operands (registered)

Behaviour:
- Reset (rst_in=1 at posedge):
  - All entries not busy.
  - alu_valid=0; every alu_* output = 0.
  - full=0 after reset.
- Priority at a posedge: rst_in > !rdy_in (hold) > clear_in > normal operation.
- clear_in: all busy bits cleared and alu_valid=0 at the next edge. Issue, wakeup and dispatch in that cycle are discarded.
- Issue:
  - Accepted when issue_valid && !full.
  - Writes into the lowest-index non-busy entry and sets busy next cycle.
  - issue_valid while full is ignored; the decoder must stall.
- Wakeup:
  - For every busy entry with qj_v=1 and qj==cdb_rob while cdb_valid: vj<=cdb_val and qj_v<=0.
  - qk is handled identically. Both operands may wake in the same cycle.
- Ready: entry is busy && !qj_v && !qk_v, evaluated on registered state. An operand woken at edge N makes its entry dispatchable for selection in cycle N (after the edge), i.e. one cycle after the broadcast.
- Dispatch:
  - Output register loads when (!alu_valid || alu_ready) and some entry is ready.
  - Loads the lowest-index ready entry. That entry's busy bit clears at the same edge.
  - If no entry is ready but alu_ready=1, alu_valid drops to 0.
  - alu_valid && !alu_ready holds all alu_* outputs stable.
- Latency: issue with resolved operands at edge N → entry busy after N → alu_valid after N+1 (minimum two edges).
- full reflects the current busy vector only. A slot freed by dispatch at edge N is reusable for issue in cycle N+1, not within the same cycle.
- Issue and dispatch are independent in the same cycle; the issue target is always a non-busy entry.
- An issue into the last free slot makes full=1 in the next cycle.

Optional Feature:
- RS_ISSUE_BYPASS_EN: defined → at issue, if issue_qj_v and cdb_valid and issue_qj==cdb_rob, the entry stores vj=cdb_val and qj_v=0 (same for k). This closes the issue/broadcast race.
- Undefined → issue fields are stored verbatim. The ROB/decoder forwarding path must resolve same-cycle broadcasts before issue.

Test Plan:
- Reset, then issue op=3, rob=2, vj=5, vk=7, no pending operands → alu_valid=1 two edges after issue, alu_rob=2, alu_vj=5, alu_vk=7.
- Issue rob=1 with qj_v=1, qj=4; one cycle later CDB rob=4, val=0x55 → dispatch vj=0x55. No dispatch occurs before the broadcast.
- Issue 16 instructions each waiting on tag 9 → full=1 and the 17th issue_valid is ignored. CDB rob=9 → entries dispatch in index order 0..15, one per accepted cycle.
- Hold alu_ready=0 with alu_valid=1, rob=3 for 4 cycles → alu_* stable and that entry's replacement does not dispatch. alu_ready=1 → next-ready entry loads.
- With 5 busy entries and alu_valid=1, assert clear_in → next cycle full=0, alu_valid=0. A subsequent issue lands in entry 0.
- RS_ISSUE_BYPASS_EN defined: issue qj=6 in the same cycle as CDB rob=6, val=0xA → dispatch with vj=0xA. Undefined: entry stays waiting.
